// File: rtl/lcd_spi_write_if.sv
// Purpose : request/handshake bundle between the drawing-side data mux and lcd_spi_write.
// Latency : wiring only, no storage.
// Backpressure: none here; the writer paces the requester through wr_done and busy.
//
// Signals:
//   en_write  level request; bytes are sent back-to-back while it is high
//   data_in   {dc, byte}: bit 8 = DC (0 command, 1 data), bits 7:0 = payload
//   wr_done   one-cycle pulse per byte, first cycle with lcd_cs high again
//   busy      writer is outside IDLE
// Modports: master = requester (drawing blocks / mux), slave = lcd_spi_write.
interface lcd_spi_write_if;
  logic       en_write;
  logic [8:0] data_in;
  logic       wr_done;
  logic       busy;

  modport master (output en_write, output data_in, input wr_done, input busy);
  modport slave  (input en_write, input data_in, output wr_done, output busy);
endinterface

// File: rtl/lcd_spi_write.sv
// Purpose : SPI mode-0 byte transmitter for the LCD, MSB first, driving CS/DC/SCLK/MOSI.
// Latency : en_write seen in IDLE -> LOAD after GAP_CYC+1 cycles; CS low 17*CLK_DIV cycles; wr_done follows.
// Backpressure: no input queue; data_in is sampled only in LOAD, requester advances on wr_done.
//
// Ports:
//   sys_clk     single clock, all logic on the rising edge
//   sys_rst_n   asynchronous active-low reset
//   req         lcd_spi_write_if.slave: en_write, data_in in; wr_done, busy out
//   lcd_cs      chip select, active low
//   lcd_dc      data/command select, held for the whole byte and after it
//   lcd_sclk    SPI clock, idle low
//   lcd_mosi    serial data, changes only on SCLK falling edges
// Parameters:
//   CLK_DIV     SCLK half-period in sys_clk cycles (>= 1)
//   GAP_CYC     settle cycles before each data_in sample (>= 4, covers the
//               drawing FSM's 3-cycle data update after wr_done)
module lcd_spi_write #(
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  lcd_spi_write_if.slave req,
  output logic           lcd_cs,
  output logic           lcd_dc,
  output logic           lcd_sclk,
  output logic           lcd_mosi
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             div_wrap;
  logic             gap_end;
  logic             last_fall;

  assign div_wrap  = (div_cnt == DIV_LAST);
  assign gap_end   = (gap_cnt == GAP_LAST);
  // The SCLK high->low toggle that ends bit 7 closes the shift phase.
  assign last_fall = div_wrap && lcd_sclk && (bit_cnt == 3'd7);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req.en_write) state_nxt = ST_WAIT;
      // en_write is re-checked only at the end of the gap, so a request
      // dropped mid-byte lets the byte finish and then parks in IDLE.
      ST_WAIT:  if (gap_end) state_nxt = req.en_write ? ST_LOAD : ST_IDLE;
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_fall) state_nxt = ST_HOLD;
      ST_HOLD:  if (div_wrap) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_WAIT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      div_cnt     <= '0;
      gap_cnt     <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      lcd_cs      <= 1'b1;
      lcd_dc      <= 1'b0;
      lcd_sclk    <= 1'b0;
      lcd_mosi    <= 1'b0;
      req.wr_done <= 1'b0;
      req.busy    <= 1'b0;
    end else begin
      state       <= state_nxt;
      // busy is registered from the next state so it lines up with state.
      req.busy    <= (state_nxt != ST_IDLE);
      req.wr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          gap_cnt <= '0;
        end
        ST_WAIT: begin
          gap_cnt <= gap_end ? '0 : gap_cnt + 1'b1;
        end
        ST_LOAD: begin
          shift_reg <= req.data_in[7:0];
          lcd_dc    <= req.data_in[8];
          lcd_mosi  <= req.data_in[7];
          lcd_cs    <= 1'b0;
          lcd_sclk  <= 1'b0;
          bit_cnt   <= '0;
          div_cnt   <= '0;
        end
        ST_SHIFT: begin
          if (div_wrap) begin
            div_cnt  <= '0;
            lcd_sclk <= ~lcd_sclk;
            // Falling edge: advance to the next bit so MOSI has a full
            // half-period of setup before the next rising edge.
            if (lcd_sclk && (bit_cnt != 3'd7)) begin
              bit_cnt   <= bit_cnt + 3'd1;
              shift_reg <= {shift_reg[6:0], 1'b0};
              lcd_mosi  <= shift_reg[6];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          // Divider reused as the CS hold timer; SCLK already low.
          if (div_wrap) begin
            div_cnt     <= '0;
            lcd_cs      <= 1'b1;
            req.wr_done <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          gap_cnt <= '0;
        end
        default: begin
          gap_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_spi_write.sv
// Purpose : self-checking bench for lcd_spi_write, CLK_DIV=2 (unit a) and CLK_DIV=1 (unit b).
// Latency : n/a (bench); a pin-level monitor decodes each byte and checks it against rule-based expectations.
// Backpressure: requester drives en_write/data_in; the model predicts each LOAD from the gap rule.
module tb_lcd_spi_write;

  localparam int GAP = 4;

  logic sys_clk;
  logic sys_rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic       en  [2];
  logic [8:0] din [2];

  lcd_spi_write_if if_a ();
  lcd_spi_write_if if_b ();

  logic cs_a, dc_a, sclk_a, mosi_a;
  logic cs_b, dc_b, sclk_b, mosi_b;

  assign if_a.en_write = en[0];
  assign if_a.data_in  = din[0];
  assign if_b.en_write = en[1];
  assign if_b.data_in  = din[1];

  lcd_spi_write #(.CLK_DIV(2), .GAP_CYC(GAP)) dut_a (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .req      (if_a),
    .lcd_cs   (cs_a),
    .lcd_dc   (dc_a),
    .lcd_sclk (sclk_a),
    .lcd_mosi (mosi_a)
  );

  lcd_spi_write #(.CLK_DIV(1), .GAP_CYC(GAP)) dut_b (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .req      (if_b),
    .lcd_cs   (cs_b),
    .lcd_dc   (dc_b),
    .lcd_sclk (sclk_b),
    .lcd_mosi (mosi_b)
  );

  logic [1:0] p_cs, p_dc, p_sclk, p_mosi, p_done, p_busy;
  assign p_cs   = {cs_b, cs_a};
  assign p_dc   = {dc_b, dc_a};
  assign p_sclk = {sclk_b, sclk_a};
  assign p_mosi = {mosi_b, mosi_a};
  assign p_done = {if_b.wr_done, if_a.wr_done};
  assign p_busy = {if_b.busy, if_a.busy};

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / pin monitor ----------------
  int         trig [2] = '{-1, -1};  // cycle of the event that starts a gap
  logic       en_end [2];            // en_write on the last gap cycle
  logic [8:0] exp_w [2];             // data_in on the predicted LOAD cycle
  int         t_fall [2], last_tog [2], nb [2];
  logic [7:0] sh [2];
  logic       dc0 [2], bad [2];
  logic       in_b [2] = '{1'b0, 1'b0};
  logic [1:0] prev_cs = 2'b11, prev_sclk = 2'b00, prev_mosi = 2'b00, prev_dc = 2'b00;
  int         rx_n [2] = '{0, 0};
  int         done_n [2] = '{0, 0};
  logic [8:0] rx_log [2][512];
  int         done_log [2][512];
  int         cd;
  logic       fell, rose;

  always @(negedge sys_clk) begin
    for (int d = 0; d < 2; d++) begin
      cd = (d == 0) ? 2 : 1;
      if (!sys_rst_n) begin
        in_b[d] = 1'b0;
        trig[d] = -1;
      end else begin
        fell = prev_cs[d] && !p_cs[d];
        rose = !prev_cs[d] && p_cs[d];
        // Gap rule: LOAD falls GAP+1 cycles after the trigger if en_write
        // is high on the last gap cycle; CS drops one cycle later.
        if (trig[d] >= 0 && cyc == trig[d] + GAP) en_end[d] = en[d];
        if (trig[d] >= 0 && cyc == trig[d] + GAP + 1) exp_w[d] = din[d];
        if (trig[d] >= 0 && cyc == trig[d] + GAP + 2) begin
          check_eq("load_decision", int'(fell), int'(en_end[d]));
          trig[d] = -1;
        end else if (fell) begin
          check_eq("stray_load", 1, 0);
        end
        if (fell) begin
          in_b[d] = 1'b1; t_fall[d] = cyc; last_tog[d] = cyc;
          nb[d] = 0; sh[d] = 8'h00; dc0[d] = p_dc[d]; bad[d] = 1'b0;
          check_eq("sclk_low_at_cs_fall", int'(p_sclk[d]), 0);
        end else if (in_b[d] && !p_cs[d]) begin
          if (p_sclk[d] != prev_sclk[d]) begin
            if (cyc - last_tog[d] != cd) bad[d] = 1'b1;
            last_tog[d] = cyc;
            if (p_sclk[d]) begin
              sh[d] = {sh[d][6:0], p_mosi[d]};
              nb[d]++;
            end
          end
          if (p_mosi[d] != prev_mosi[d] && !(prev_sclk[d] && !p_sclk[d])) bad[d] = 1'b1;
          if (p_dc[d] != dc0[d]) bad[d] = 1'b1;
        end else if (p_sclk[d]) begin
          check_eq("sclk_idle_low", 1, 0);
        end
        if (rose && in_b[d]) begin
          check_eq("cs_low_len", cyc - t_fall[d], 17 * cd);
          check_eq("sclk_rises", nb[d], 8);
          check_eq("byte", int'({dc0[d], sh[d]}), int'(exp_w[d]));
          check_eq("wr_done_at_cs_rise", int'(p_done[d]), 1);
          check_eq("pin_timing_ok", int'(bad[d]), 0);
          if (rx_n[d] < 512) rx_log[d][rx_n[d]] = {dc0[d], sh[d]};
          rx_n[d]++;
          in_b[d] = 1'b0;
        end
        if (p_done[d]) begin
          if (!rose) check_eq("stray_wr_done", 1, 0);
          if (done_n[d] < 512) done_log[d][done_n[d]] = cyc;
          done_n[d]++;
          trig[d] = cyc;
        end else if (!p_busy[d] && en[d]) begin
          trig[d] = cyc;
        end
        if (!fell && !in_b[d] && p_dc[d] != prev_dc[d])
          check_eq("dc_hold", int'(p_dc[d]), int'(prev_dc[d]));
      end
      prev_cs[d]   = p_cs[d];
      prev_sclk[d] = p_sclk[d];
      prev_mosi[d] = p_mosi[d];
      prev_dc[d]   = p_dc[d];
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_done(input int d, input int budget);
    int k;
    k = 0;
    do begin
      tick(1);
      k++;
    end while (!p_done[d] && k < budget);
    check_eq("wr_done_seen", int'(p_done[d]), 1);
  endtask

  task automatic send_one(input int d, input logic [8:0] w);
    int dn0;
    dn0 = done_n[d];
    din[d] = w;
    en[d]  = 1'b1;
    tick(GAP + 3);
    din[d] = 9'($urandom);
    wait_done(d, 200);
    en[d] = 1'b0;
    tick(GAP + 2);
    check_eq("idle_after_byte", int'(p_busy[d]), 0);
    check_eq("last_word", int'(rx_log[d][rx_n[d] - 1]), int'(w));
    check_eq("one_wr_done", done_n[d] - dn0, 1);
  endtask

  task automatic check_reset_pins(input int d);
    check_eq("rst_cs", int'(p_cs[d]), 1);
    check_eq("rst_sclk", int'(p_sclk[d]), 0);
    check_eq("rst_mosi", int'(p_mosi[d]), 0);
    check_eq("rst_dc", int'(p_dc[d]), 0);
    check_eq("rst_wr_done", int'(p_done[d]), 0);
    check_eq("rst_busy", int'(p_busy[d]), 0);
  endtask

  logic [8:0] win_seq [11] = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h10F, 9'h02B,
                               9'h100, 9'h10A, 9'h100, 9'h10F, 9'h02C};

  initial begin
    int rx0, dn0;
    en[0] = 1'b0; en[1] = 1'b0; din[0] = '0; din[1] = '0;
    sys_rst_n = 1'b1;
    #1 sys_rst_n = 1'b0;
    #2;
    check_reset_pins(0);
    check_reset_pins(1);
    tick(3);
    sys_rst_n = 1'b1;
    tick(2);

    // single command byte, then data bytes
    send_one(0, 9'h02A);
    send_one(0, 9'h1F8);
    send_one(0, 9'h100);

    // window sequence: en_write held, data_in updated 3 cycles after wr_done
    rx0 = rx_n[0]; dn0 = done_n[0];
    din[0] = win_seq[0];
    en[0]  = 1'b1;
    tick(GAP + 3);
    din[0] = 9'($urandom);
    for (int i = 1; i < 11; i++) begin
      wait_done(0, 200);
      tick(3);
      din[0] = win_seq[i];
      tick(4);
      din[0] = 9'($urandom);
    end
    wait_done(0, 200);
    en[0] = 1'b0;
    tick(GAP + 2);
    check_eq("win_count", rx_n[0] - rx0, 11);
    check_eq("win_done_count", done_n[0] - dn0, 11);
    for (int i = 0; i < 11; i++)
      check_eq("win_word", int'(rx_log[0][rx0 + i]), int'(win_seq[i]));
    for (int i = 1; i < 11; i++)
      check_eq("win_spacing", done_log[0][dn0 + i] - done_log[0][dn0 + i - 1], 40);

    // minimum divider
    send_one(1, 9'h1A5);

    // early deassert during bit 3
    dn0 = done_n[0];
    din[0] = 9'h1C3;
    en[0]  = 1'b1;
    tick(GAP + 3);
    din[0] = 9'($urandom);
    tick(12);
    check_eq("in_byte_at_deassert", int'(p_cs[0]), 0);
    en[0] = 1'b0;
    wait_done(0, 200);
    tick(GAP + 2);
    check_eq("early_idle", int'(p_busy[0]), 0);
    tick(40);
    check_eq("early_one_done", done_n[0] - dn0, 1);
    check_eq("early_word", int'(rx_log[0][rx_n[0] - 1]), 32'h1C3);

    // randomized traffic on both units; data_in changes every cycle
    for (int k = 0; k < 3000; k++) begin
      en[0]  = ($urandom_range(0, 9) < 8);
      en[1]  = ($urandom_range(0, 9) < 6);
      din[0] = 9'($urandom);
      din[1] = 9'($urandom);
      tick(1);
    end
    en[0] = 1'b0; en[1] = 1'b0;
    tick(100);
    check_eq("rand_busy_a", int'(p_busy[0]), 0);
    check_eq("rand_busy_b", int'(p_busy[1]), 0);
    check_eq("rand_rx_vs_done_a", rx_n[0], done_n[0]);
    check_eq("rand_rx_vs_done_b", rx_n[1], done_n[1]);

    // reset during bit 5
    rx0 = rx_n[0]; dn0 = done_n[0];
    din[0] = 9'h1FF;
    en[0]  = 1'b1;
    tick(GAP + 3);
    tick(20);
    check_eq("pre_reset_mosi", int'(p_mosi[0]), 1);
    #2;
    sys_rst_n = 1'b0;
    en[0] = 1'b0;
    #1;
    check_reset_pins(0);
    tick(3);
    sys_rst_n = 1'b1;
    tick(2);
    check_eq("reset_no_done", done_n[0] - dn0, 0);
    send_one(0, 9'h0AA);
    check_eq("reset_rx_count", rx_n[0] - rx0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lcd_spi_write.md
# lcd_spi_write

SPI byte transmitter for the LCD path. It accepts 9-bit words `{dc, byte}` from the character/graphics drawing blocks and serialises each byte MSB-first in SPI mode 0, driving CS, DC, SCLK and MOSI. It returns a one-cycle `wr_done` pulse per byte, which the drawing blocks use to advance. It sits between the drawing FSMs (through the top-level data mux) and the LCD pins.

## Interface
- `CLK_DIV`, default 2: SCLK half-period in `sys_clk` cycles. Must be ≥1.
- `GAP_CYC`, default 4: settle cycles before sampling `data_in`, counted after `en_write` is first seen high and after every `wr_done`. Must be ≥4, to cover the drawing FSM's 3-cycle data-update latency.
- `sys_clk` in 1: the single clock. All logic is on its rising edge.
- `sys_rst_n` in 1: asynchronous active-low reset.
- `en_write` in 1: level request. While high, bytes are transferred back-to-back.
- `data_in` in 9: bit 8 = DC (0 command, 1 data); bits 7:0 = payload.
- `wr_done` out 1: one-cycle pulse at the end of each byte.
- `busy` out 1: high in every state except IDLE.
- `lcd_cs` out 1: chip select, active low.
- `lcd_dc` out 1: data/command select, held for the whole byte.
- `lcd_sclk` out 1: SPI clock, idle low.
- `lcd_mosi` out 1: serial data, MSB first.

## Operation
- All outputs are registered.
- Reset values: `lcd_cs`=1, `lcd_sclk`=0, `lcd_mosi`=0, `lcd_dc`=0, `wr_done`=0, `busy`=0, state=IDLE, all counters 0.

States:
- **IDLE**
  - `en_write`=1 → WAIT, with the gap counter cleared.
- **WAIT**
  - Counts GAP_CYC cycles.
  - At count end: `en_write`=1 → LOAD; otherwise → IDLE.
- **LOAD** (1 cycle)
  - Latch `data_in[7:0]` into the shift register and `data_in[8]` into `lcd_dc`.
  - Set `lcd_cs`←0, `lcd_mosi`←`data_in[7]`, `lcd_sclk`←0; clear the bit and divider counters.
  - → SHIFT.
- **SHIFT**
  - The divider counts 0..CLK_DIV-1; at CLK_DIV-1 it wraps and `lcd_sclk` toggles.
  - On a high→low toggle with bit_cnt<7: bit_cnt++, and `lcd_mosi` takes the next bit. MOSI changes only on SCLK falling edges.
  - On the high→low toggle with bit_cnt=7: → HOLD, with SCLK low.
- **HOLD**
  - CLK_DIV cycles with CS low and SCLK low.
  - Then `lcd_cs`←1, `wr_done`←1, → DONE.
- **DONE** (1 cycle)
  - `wr_done` is high here only.
  - → WAIT, with the gap counter cleared.

Boundary behaviour:
- **`data_in` sampling:** `data_in` is sampled only in LOAD. Changes at any other time are ignored.
- **`en_write` deasserted mid-byte:** the byte completes normally, `wr_done` is still pulsed, and WAIT then returns to IDLE.
- **`en_write` high continuously:** the block repeats the sequence LOAD..DONE, WAIT indefinitely. The requester is responsible for dropping `en_write`.
- **Reset mid-byte:** all outputs go immediately to their reset values. No `wr_done` is issued and the partial byte is discarded.
- **`lcd_dc` between bytes:** holds its last value after CS rises.

## Timing
- **Sample to CS fall:** `data_in` is sampled at the LOAD edge; `lcd_cs` falls in the next cycle.
- **CS low duration:** exactly 17·CLK_DIV cycles (8 bits × 2·CLK_DIV, plus CLK_DIV hold).
- **`wr_done`:** asserted in the first cycle that `lcd_cs` is high.
- **SCLK:** first rising edge comes CLK_DIV cycles after CS falls; there are 8 rising edges per byte.
- **MOSI:** stable for CLK_DIV cycles before and after every rising edge.
- **Byte period (`en_write` held):** wr_done-to-wr_done = 17·CLK_DIV + GAP_CYC + 2 cycles. With the defaults this is 40.
- **First byte:** `en_write` rise to LOAD = GAP_CYC + 1 cycles.

## Test plan
- **Single command byte:** CLK_DIV=2, `data_in`=0x02A, `en_write` pulsed high until `wr_done` and then low.
  - Bits 00101010 captured on SCLK rising edges, `lcd_dc`=0.
  - CS low for 34 cycles, one `wr_done`, return to IDLE with `busy`=0.
- **Data byte:** `data_in`=0x1F8, i.e. the RED high byte.
  - `lcd_dc`=1, bits 11111000.
  - Then `data_in`=0x100 gives 00000000 with `lcd_dc`=1.
- **Window sequence with a model requester:** the requester updates `data_in` 3 cycles after each `wr_done`, with `en_write` held.
  - Sequence sent: 0x02A, 0x100, 0x10A, 0x100, 0x10F, 0x02B, …, 0x02C.
  - All 11 bytes appear in order, 11 `wr_done` pulses, 40-cycle spacing.
- **Minimum divider:** CLK_DIV=1, byte 0x1A5.
  - SCLK toggles every cycle.
  - CS low for 17 cycles; bits 10100101 are correct.
- **Early deassert:** `en_write` dropped during bit 3 of 0x1C3.
  - The full byte 11000011 is sent and `wr_done` pulses.
  - After GAP_CYC cycles the block is in IDLE and no second LOAD occurs.
- **Reset during transfer:** `sys_rst_n` asserted during bit 5.
  - Same cycle: `lcd_cs`=1, `lcd_sclk`=0, `lcd_mosi`=0, `wr_done`=0.
  - After release, a new byte 0x0AA transfers correctly.
